// File: rtl/imuldiv_int_mul_iterative_param.sv
// Iterative shift-add multiplier, W-bit operands, 2W-bit product, signed or unsigned per request.
// Latency: W+1 cycles from accept to response valid, or k+1 cycles with EARLY_TERM (k = significant bits of |b|, min 1).
// Backpressure: one transaction in flight; request ready only in IDLE, result held in DONE until response ready.
module imuldiv_int_mul_iterative_param #(
  parameter int W          = 32,
  parameter int EARLY_TERM = 0
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [W-1:0]   i_mulreq_msg_a,
  input  logic [W-1:0]   i_mulreq_msg_b,
  input  logic           i_mulreq_msg_signed,
  input  logic           i_mulreq_val,
  output logic           o_mulreq_rdy,
  output logic [2*W-1:0] o_mulresp_msg_result,
  output logic           o_mulresp_val,
  input  logic           i_mulresp_rdy
);

  localparam int           CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  // ST_FIN is the tail of the calculation: the sign fix-up gets its own cycle so the
  // 2W-bit negate never sits behind the 2W-bit accumulate adder.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIN,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2*W-1:0]   r_a;
  logic [W-1:0]     r_b;
  logic [2*W-1:0]   r_result;
  logic             r_sgn;
  logic             r_req_rdy;
  logic             r_resp_val;
  logic [2*W-1:0]   r_resp_result;

  logic             w_accept;
  logic [W-1:0]     w_a_mag;
  logic [W-1:0]     w_b_mag;
  logic [2*W-1:0]   w_sum;
  logic [W-1:0]     w_b_next;
  logic             w_last;

  // Operand magnitudes; the most negative value maps to its unsigned magnitude 2^(W-1).
  assign w_accept = r_req_rdy & i_mulreq_val;
  assign w_a_mag  = (i_mulreq_msg_signed & i_mulreq_msg_a[W-1]) ? -i_mulreq_msg_a : i_mulreq_msg_a;
  assign w_b_mag  = (i_mulreq_msg_signed & i_mulreq_msg_b[W-1]) ? -i_mulreq_msg_b : i_mulreq_msg_b;

  // One shift-add step; the sum cannot overflow since |a|*|b| < 2^(2W).
  assign w_sum    = r_b[0] ? (r_result + r_a) : r_result;
  assign w_b_next = r_b >> 1;
  assign w_last   = (r_cnt == LAST) || ((EARLY_TERM != 0) && (w_b_next == '0));

  // Control FSM and datapath registers; reset wins over every other event.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_result      <= '0;
      r_sgn         <= 1'b0;
      r_req_rdy     <= 1'b1;
      r_resp_val    <= 1'b0;
      r_resp_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sgn     <= i_mulreq_msg_signed & (i_mulreq_msg_a[W-1] ^ i_mulreq_msg_b[W-1]);
            r_a       <= {{W{1'b0}}, w_a_mag};
            r_b       <= w_b_mag;
            r_result  <= '0;
            r_cnt     <= '0;
            r_req_rdy <= 1'b0;
            r_state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_result <= w_sum;
          r_a      <= r_a << 1;
          r_b      <= w_b_next;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_resp_result <= r_sgn ? -r_result : r_result;
          r_resp_val    <= 1'b1;
          r_state       <= ST_DONE;
        end
        ST_DONE: begin
          if (i_mulresp_rdy) begin
            r_resp_val <= 1'b0;
            r_req_rdy  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_req_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign o_mulreq_rdy         = r_req_rdy;
  assign o_mulresp_val        = r_resp_val;
  assign o_mulresp_msg_result = r_resp_result;

endmodule

// File: tb/tb_imuldiv_int_mul_iterative_param.sv
// Directed checks of the iterative multiplier: a W=32 full-length instance and a W=8 early-terminating instance.
// Latency is measured in rising edges from the accepting edge to the first edge after which response valid is seen.
// Response ready is held low for a stretch to confirm the result holds and no new request is taken.
module tb_imuldiv_int_mul_iterative_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;

  // W=32, full W-step calculation
  logic        rst32;
  logic [31:0] a32, b32;
  logic        sgn32, req_val32, req_rdy32, resp_val32, resp_rdy32;
  logic [63:0] res32;

  // W=8, early termination
  logic        rst8;
  logic [7:0]  a8, b8;
  logic        sgn8, req_val8, req_rdy8, resp_val8, resp_rdy8;
  logic [15:0] res8;

  imuldiv_int_mul_iterative_param #(.W(32), .EARLY_TERM(0)) dut32 (
    .i_clk                (clk),
    .i_reset              (rst32),
    .i_mulreq_msg_a       (a32),
    .i_mulreq_msg_b       (b32),
    .i_mulreq_msg_signed  (sgn32),
    .i_mulreq_val         (req_val32),
    .o_mulreq_rdy         (req_rdy32),
    .o_mulresp_msg_result (res32),
    .o_mulresp_val        (resp_val32),
    .i_mulresp_rdy        (resp_rdy32)
  );

  imuldiv_int_mul_iterative_param #(.W(8), .EARLY_TERM(1)) dut8 (
    .i_clk                (clk),
    .i_reset              (rst8),
    .i_mulreq_msg_a       (a8),
    .i_mulreq_msg_b       (b8),
    .i_mulreq_msg_signed  (sgn8),
    .i_mulreq_val         (req_val8),
    .o_mulreq_rdy         (req_rdy8),
    .o_mulresp_msg_result (res8),
    .o_mulresp_val        (resp_val8),
    .i_mulresp_rdy        (resp_rdy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, scramble the operands afterwards, then count edges until valid.
  task automatic req32(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
    a32 = a; b32 = b; sgn32 = s; req_val32 = 1'b1;
    tick();
    req_val32 = 1'b0;
    a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; sgn32 = ~s;
    lat = 0;
    while (!resp_val32 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic resp32();
    resp_rdy32 = 1'b1;
    tick();
    resp_rdy32 = 1'b0;
  endtask

  task automatic req8(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
    a8 = a; b8 = b; sgn8 = s; req_val8 = 1'b1;
    tick();
    req_val8 = 1'b0;
    a8 = 8'h5A; b8 = 8'hC3; sgn8 = ~s;
    lat = 0;
    while (!resp_val8 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic resp8();
    resp_rdy8 = 1'b1;
    tick();
    resp_rdy8 = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [7:0]  ra, rb, bmag;
    logic        rs;
    logic signed [15:0] sa, sb, sp;
    logic [15:0] exp8;
    int          k;

    rst32 = 1'b1; a32 = '0; b32 = '0; sgn32 = 1'b0; req_val32 = 1'b0; resp_rdy32 = 1'b0;
    rst8  = 1'b1; a8  = '0; b8  = '0; sgn8  = 1'b0; req_val8  = 1'b0; resp_rdy8  = 1'b0;
    tick();
    tick();
    rst32 = 1'b0;
    rst8  = 1'b0;

    // Reset state
    chk("rst_req_rdy",  64'(req_rdy32),  64'd1);
    chk("rst_resp_val", 64'(resp_val32), 64'd0);
    chk("rst_result",   res32,           64'd0);

    // Signed -3 * 5
    req32(32'hFFFF_FFFD, 32'd5, 1'b1, lat);
    chk("s_m3x5_lat", 64'(lat), 64'd33);
    chk("s_m3x5_res", res32, 64'hFFFF_FFFF_FFFF_FFF1);
    resp32();

    // All-ones, unsigned then signed
    req32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    chk("u_ff_res", res32, 64'hFFFF_FFFE_0000_0001);
    resp32();
    req32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
    chk("s_ff_res", res32, 64'h0000_0000_0000_0001);
    resp32();

    // Most negative operand
    req32(32'h8000_0000, 32'h8000_0000, 1'b1, lat);
    chk("s_min_sq", res32, 64'h4000_0000_0000_0000);
    resp32();
    req32(32'h8000_0000, 32'd1, 1'b1, lat);
    chk("s_min_x1", res32, 64'hFFFF_FFFF_8000_0000);
    resp32();

    // Zero operand with a negative partner
    req32(32'd0, 32'hFFFF_FFFB, 1'b1, lat);
    chk("s_0xm5", res32, 64'd0);
    resp32();

    // Backpressure: hold response ready low for 10 cycles
    req32(32'd7, 32'd6, 1'b0, lat);
    chk("bp_lat", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_val", 64'(resp_val32), 64'd1);
      chk("bp_rdy", 64'(req_rdy32),  64'd0);
      chk("bp_res", res32,           64'd42);
    end
    resp32();
    chk("bp_after_val", 64'(resp_val32), 64'd0);
    chk("bp_after_rdy", 64'(req_rdy32),  64'd1);
    // Back-to-back request in the cycle right after the handshake
    req32(32'd11, 32'd13, 1'b0, lat);
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_res", res32, 64'd143);
    resp32();

    // Reset five cycles into the calculation
    a32 = 32'd100; b32 = 32'd200; sgn32 = 1'b0; req_val32 = 1'b1;
    tick();
    req_val32 = 1'b0;
    chk("mid_calc_rdy", 64'(req_rdy32), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    rst32 = 1'b1;
    tick();
    rst32 = 1'b0;
    chk("mid_rst_val", 64'(resp_val32), 64'd0);
    chk("mid_rst_rdy", 64'(req_rdy32),  64'd1);
    chk("mid_rst_res", res32,           64'd0);
    req32(32'd7, 32'd6, 1'b0, lat);
    chk("post_rst_lat", 64'(lat), 64'd33);
    chk("post_rst_res", res32, 64'd42);
    resp32();

    // W=8 early termination
    req8(8'h25, 8'h01, 1'b0, lat);
    chk("et_b1_lat", 64'(lat), 64'd2);
    chk("et_b1_res", 64'(res8), 64'h25);
    resp8();
    req8(8'h03, 8'h80, 1'b0, lat);
    chk("et_b80_lat", 64'(lat), 64'd9);
    chk("et_b80_res", 64'(res8), 64'h0180);
    resp8();
    req8(8'h37, 8'h00, 1'b0, lat);
    chk("et_b0_lat", 64'(lat), 64'd2);
    chk("et_b0_res", 64'(res8), 64'h0000);
    resp8();
    req8(8'h80, 8'h80, 1'b1, lat);
    chk("et_min_sq_res", 64'(res8), 64'h4000);
    resp8();

    // Random signed/unsigned pairs against an arithmetic reference
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      rs = 1'($urandom_range(1));
      if (rs) begin
        sa   = {{8{ra[7]}}, ra};
        sb   = {{8{rb[7]}}, rb};
        sp   = sa * sb;
        exp8 = sp;
        bmag = rb[7] ? 8'(-rb) : rb;
      end else begin
        exp8 = 16'(ra) * 16'(rb);
        bmag = rb;
      end
      k = 1;
      for (int j = 0; j < 8; j++) begin
        if (bmag[j]) k = j + 1;
      end
      req8(ra, rb, rs, lat);
      chk("rnd_res", 64'(res8), 64'(exp8));
      chk("rnd_lat", 64'(lat), 64'(k + 1));
      resp8();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
